// File: rtl/peak_hold_register.sv
// peak_hold_register: holds the first-occurring maximum ADC sample of a servo sweep and its position.
// Optional sweep watchdog is compiled in when PEAK_HOLD_WATCHDOG_EN is defined.
module peak_hold_register #(
  parameter int DATA_W      = 8,
  parameter int POS_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sweep_end,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] pv,
  input  logic [POS_W-1:0]  pos,
  input  logic              gt,
  output logic [DATA_W-1:0] lv,
  output logic [POS_W-1:0]  max_pos,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  // state    | meaning
  // ST_IDLE  | waiting for start, results held
  // ST_SWEEP | accepting samples, one compare in flight at most
  // ST_FLUSH | end seen with a compare still pending; resolve it
  // ST_DONE  | one-cycle completion pulse, then back to idle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] lv_q, lv_d;
  logic [DATA_W-1:0] pv_q, pv_d;
  logic [POS_W-1:0]  max_pos_q, max_pos_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              resolve;

`ifdef PEAK_HOLD_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             wd_hit;

  assign wd_hit = (wd_cnt_q == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d   = state_q;
    lv_d      = lv_q;
    max_pos_d = max_pos_q;
    pv_d      = pv_q;
    pos_d     = pos_q;
    pend_d    = pend_q;
`ifdef PEAK_HOLD_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
`endif
    accept  = (state_q == ST_SWEEP) && sample_valid && !pend_q && !start;
    resolve = pend_q && ((state_q == ST_SWEEP) || (state_q == ST_FLUSH));

    if (start) begin
      state_d   = ST_SWEEP;
      lv_d      = '0;
      max_pos_d = '0;
      pend_d    = 1'b0;
`ifdef PEAK_HOLD_WATCHDOG_EN
      wd_cnt_d  = '0;
`endif
    end else begin
      // gt was registered on the acceptance edge, so it compares pv_q against the current lv
      if (resolve) begin
        if (gt) begin
          lv_d      = pv_q;
          max_pos_d = pos_q;
        end
        pend_d = 1'b0;
      end
      if (accept) begin
        pv_d   = pv;
        pos_d  = pos;
        pend_d = 1'b1;
      end

      case (state_q)
        ST_SWEEP: if (sweep_end) state_d = accept ? ST_FLUSH : ST_DONE;
        ST_FLUSH: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

`ifdef PEAK_HOLD_WATCHDOG_EN
      wd_cnt_d = ((state_d == ST_SWEEP) || (state_d == ST_FLUSH)) ? wd_cnt_q + CNT_W'(1) : '0;
      if ((state_q == ST_SWEEP) && !sweep_end && wd_hit) begin
        timeout_d = 1'b1;
        lv_d      = '0;
        max_pos_d = '0;
        pend_d    = 1'b0;
        wd_cnt_d  = '0;
        state_d   = ST_IDLE;
      end
`endif
    end

    busy_d = (state_d == ST_SWEEP) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lv_q      <= '0;
      max_pos_q <= '0;
      pv_q      <= '0;
      pos_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lv_q      <= lv_d;
      max_pos_q <= max_pos_d;
      pv_q      <= pv_d;
      pos_q     <= pos_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef PEAK_HOLD_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign lv      = lv_q;
  assign max_pos = max_pos_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_peak_hold_register.sv
// Self-checking bench for peak_hold_register: directed scenarios then randomized sweeps,
// all checked against a sweep-level model (first-occurring maximum of accepted samples).
module tb_peak_hold_register;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int TO = 16;
`ifdef PEAK_HOLD_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sweep_end = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] pv = '0;
  logic [PW-1:0] pos = '0;
  logic          gt;
  logic [DW-1:0] lv;
  logic [PW-1:0] max_pos;
  logic          busy;
  logic          done;
  logic          timeout;

  int total = 0;
  int bad = 0;

  // sweep-level reference state
  bit m_in_sweep, m_prev_acc, m_flush, m_done, m_to;
  int m_wd, m_best_v, m_best_p;

  peak_hold_register #(.DATA_W(DW), .POS_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_end(sweep_end),
    .sample_valid(sample_valid), .pv(pv), .pos(pos), .gt(gt),
    .lv(lv), .max_pos(max_pos), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // external registered comparator
  always @(posedge clk or negedge rst_n)
    if (!rst_n) gt <= 1'b0;
    else        gt <= (pv > lv);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_sweep = 0; m_prev_acc = 0; m_flush = 0; m_done = 0; m_to = 0;
    m_wd = 0; m_best_v = 0; m_best_p = 0;
  endtask

  task automatic model_edge(input bit s, input bit e, input bit v, input int pvv, input int posv);
    bit acc;
    m_done = 0;
    m_to = 0;
    if (s) begin
      m_in_sweep = 1; m_flush = 0; m_prev_acc = 0;
      m_best_v = 0; m_best_p = 0; m_wd = 0;
    end else if (m_flush) begin
      m_flush = 0;
      m_done = 1;
    end else if (m_in_sweep) begin
      acc = v && !m_prev_acc;
      if (acc && pvv > m_best_v) begin
        m_best_v = pvv;
        m_best_p = posv;
      end
      m_prev_acc = acc;
      m_wd++;
      if (e) begin
        m_in_sweep = 0;
        if (acc) m_flush = 1;
        else     m_done = 1;
      end else if (WD && m_wd == TO) begin
        m_in_sweep = 0; m_to = 1; m_best_v = 0; m_best_p = 0;
      end
    end
  endtask

  task automatic step(input bit s, input bit e, input bit v, input int pvv, input int posv);
    start = s; sweep_end = e; sample_valid = v;
    pv = DW'(pvv); pos = PW'(posv);
    @(posedge clk);
    model_edge(s, e, v, pvv, posv);
    #1;
    chk("busy", 32'(busy), 32'(m_in_sweep || m_flush));
    chk("done", 32'(done), 32'(m_done));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (!(m_in_sweep || m_flush)) begin
      chk("lv", 32'(lv), m_best_v);
      chk("max_pos", 32'(max_pos), m_best_p);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lv", 32'(lv), 0);
    chk("rst_max_pos", 32'(max_pos), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;

    // basic peak
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 10, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 50, 1); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 30, 2); step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("basic_done", 32'(done), 1);
    chk("basic_lv", 32'(lv), 50);
    chk("basic_pos", 32'(max_pos), 1);
    step(0, 0, 0, 0, 0);
    chk("basic_done_1cyc", 32'(done), 0);

    // tie: first occurrence wins
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 40, 3); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 40, 7); step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("tie_lv", 32'(lv), 40);
    chk("tie_pos", 32'(max_pos), 3);

    // back-to-back valid: second sample dropped
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 20, 1);
    step(0, 0, 1, 90, 2);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("b2b_lv", 32'(lv), 20);
    chk("b2b_pos", 32'(max_pos), 1);

    // end coinciding with an accepted sample goes through flush
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 200, 9);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_no_done", 32'(done), 0);
    step(0, 0, 0, 0, 0);
    chk("flush_done", 32'(done), 1);
    chk("flush_lv", 32'(lv), 200);
    chk("flush_pos", 32'(max_pos), 9);

    // start with end restarts the sweep
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 60, 2); step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("restart_busy", 32'(busy), 1);
    step(0, 1, 0, 0, 0);
    chk("restart_lv", 32'(lv), 0);

    // reset mid-sweep
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 77, 4); step(0, 0, 0, 0, 0);
    chk("mid_lv", 32'(lv), 77);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lv", 32'(lv), 0);
    chk("async_pos", 32'(max_pos), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_timeout", 32'(timeout), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 33, 5); step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("post_rst_lv", 32'(lv), 33);
    chk("post_rst_pos", 32'(max_pos), 5);

    // watchdog behaviour
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 99, 6);
    repeat (TO - 1) step(0, 0, 0, 0, 0);
`ifdef PEAK_HOLD_WATCHDOG_EN
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_lv", 32'(lv), 0);
    chk("wd_busy", 32'(busy), 0);
    step(0, 0, 0, 0, 0);
    chk("wd_timeout_1cyc", 32'(timeout), 0);
`else
    repeat (3 * TO) step(0, 0, 0, 0, 0);
    chk("nowd_timeout", 32'(timeout), 0);
    chk("nowd_busy", 32'(busy), 1);
    step(0, 1, 0, 0, 0);
    chk("nowd_lv", 32'(lv), 99);
`endif

    // randomized sweeps
    for (int i = 0; i < 1500; i++) begin
      bit s, e, v;
      int pvv, posv;
      s = m_in_sweep ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 2) != 0);
      pvv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : 8 * int'($urandom_range(0, 4));
      posv = int'($urandom_range(0, 255));
      step(s, e, v, pvv, posv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peak_hold_register.md
PEAK_HOLD_REGISTER -- requirements
Module: peak_hold_register

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of the ADC sample and held peak value.
REQ-002 SHALL have parameter POS_W, default 8, meaning the width of the servo position tag.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the sweep watchdog limit in CLK cycles (used only when the macro is defined).
REQ-004 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  single-cycle pulse that starts (or restarts) a sweep.
REQ-007 END  input  1  single-cycle pulse that ends the sweep.
REQ-008 SAMPLE_VALID  input  1  PV and POS are valid this cycle.
REQ-009 PV  input  DATA_W  pending ADC value; also feeds the external comparator.
REQ-010 POS  input  POS_W  servo position associated with PV.
REQ-011 GT  input  1  registered comparator flag: (PV > LV) from the previous cycle.
REQ-012 LV  output  DATA_W  held peak value; drives the comparator LV input.
REQ-013 MAX_POS  output  POS_W  position at which LV was captured.
REQ-014 BUSY  output  1  high in SWEEP or FLUSH.
REQ-015 DONE  output  1  one-cycle pulse on entry to DONE.
REQ-016 TIMEOUT  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 SHALL implement the states IDLE, SWEEP, FLUSH and DONE.
REQ-018 From any state, START SHALL clear LV, MAX_POS, PEND and the watchdog counter, then enter SWEEP.
REQ-019 A sample SHALL be accepted in SWEEP only when SAMPLE_VALID=1 and PEND=0, and START=0.
REQ-020 On acceptance, the block SHALL register PV_Q<=PV and POS_Q<=POS, and set PEND<=1.
REQ-021 On the edge after acceptance, when PEND=1: if GT=1, then LV<=PV_Q and MAX_POS<=POS_Q; PEND SHALL clear regardless of GT.
REQ-022 Minimum accepted-sample spacing SHALL be 2 cycles; SAMPLE_VALID while PEND=1 SHALL be silently dropped, so the comparator never sees a stale LV.
REQ-023 Equal values (PV == LV, GT=0) SHALL NOT update LV or MAX_POS, so the first occurrence of a peak wins; a sweep of all-zero samples leaves LV=0 and MAX_POS=0.
REQ-024 END in SWEEP SHALL enter DONE when PEND=0 after the same edge, else enter FLUSH.
REQ-025 FLUSH SHALL resolve the pending update on its one cycle and then enter DONE.
REQ-026 When END and an accepted sample coincide, the sample SHALL be taken and the FSM SHALL enter FLUSH.
REQ-027 DONE SHALL pulse for exactly one cycle; in DONE, LV and MAX_POS SHALL hold until the next START.
REQ-028 END, SAMPLE_VALID and GT SHALL be ignored in IDLE and DONE.
REQ-029 START coinciding with END SHALL take priority: the sweep restarts.
REQ-030 BUSY SHALL be a registered decode of the state.

Reset
REQ-031 RST_N=0 SHALL asynchronously force: state IDLE, LV=0, MAX_POS=0, PV_Q=0, POS_Q=0, PEND=0, BUSY=0, DONE=0, TIMEOUT=0, watchdog counter=0.
REQ-032 Reset asserted mid-sweep SHALL discard all results; no DONE pulse SHALL occur.
REQ-033 Release SHALL be synchronous-safe: the first active edge after deassertion SHALL evaluate normally.

Configuration
REQ-034 Macro PEAK_HOLD_WATCHDOG_EN defined: a counter SHALL increment each cycle in SWEEP or FLUSH.
REQ-035 With the macro defined, on reaching TIMEOUT_CYC-1 without END the block SHALL pulse TIMEOUT for one cycle, clear LV and MAX_POS, and enter IDLE without a DONE pulse.
REQ-036 Macro undefined: no counter SHALL be present, TIMEOUT SHALL be tied to 0, and the sweep SHALL wait indefinitely for END.

Verification
REQ-037 Basic peak: START; samples (PV,POS) = (10,0),(50,1),(30,2) every 2 cycles with a model comparator; END -> DONE pulse, LV=50, MAX_POS=1.
REQ-038 Tie/first-wins: samples (40,3),(40,7); END -> LV=40, MAX_POS=3.
REQ-039 Back-to-back: SAMPLE_VALID on consecutive cycles with (20,1),(90,2) -> second dropped; LV=20, MAX_POS=1.
REQ-040 END with sample (200,9) in the same cycle -> FLUSH for 1 cycle, then DONE; LV=200, MAX_POS=9; BUSY high through FLUSH.
REQ-041 RST_N low mid-sweep after LV=77 -> all outputs 0 immediately; no DONE; a new START then sweeps normally.
REQ-042 PEAK_HOLD_WATCHDOG_EN with TIMEOUT_CYC=16: START, no END -> TIMEOUT pulse 16 cycles after START, LV=0, BUSY=0; without the macro, TIMEOUT stays 0.
